// File: rtl/argmax_classifier.sv
// Sequential argmax: latches a signed vector, scans one element per cycle, reports the max index/value.
// Optional ARGMAX_OVERRUN_FLAG_EN adds a sticky flag for vectors presented while busy.
module argmax_classifier #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_INPUTS = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inputs_ready,
    input  logic signed [DATA_WIDTH-1:0]  inputs [NUM_INPUTS],
    output logic [$clog2(NUM_INPUTS)-1:0] class_index,
    output logic signed [DATA_WIDTH-1:0]  max_value,
    output logic                          output_ready,
    output logic                          busy
`ifdef ARGMAX_OVERRUN_FLAG_EN
    ,
    output logic                          overrun
`endif
);

    localparam int unsigned INDEX_WIDTH = $clog2(NUM_INPUTS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
        $error("argmax_classifier: NUM_INPUTS must be >= 2");
    end

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic signed [DATA_WIDTH-1:0] r_vec [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0] r_best_val;
    logic [INDEX_WIDTH-1:0]       r_best_idx;
    logic [INDEX_WIDTH-1:0]       r_scan_idx;

    logic signed [DATA_WIDTH-1:0] w_elem;
    logic                         w_take;
    logic                         w_last;
    logic signed [DATA_WIDTH-1:0] w_cand_val;
    logic [INDEX_WIDTH-1:0]       w_cand_idx;

    // Strict compare keeps the lowest index among equal maxima.
    assign w_elem     = r_vec[r_scan_idx];
    assign w_take     = (w_elem > r_best_val);
    assign w_last     = (r_scan_idx == INDEX_WIDTH'(NUM_INPUTS - 1));
    assign w_cand_val = w_take ? w_elem : r_best_val;
    assign w_cand_idx = w_take ? r_scan_idx : r_best_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (inputs_ready) w_next_state = ST_SCAN;
            ST_SCAN: if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; results only update on the final scan edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vec        <= '{default: '0};
            r_best_val   <= '0;
            r_best_idx   <= '0;
            r_scan_idx   <= '0;
            class_index  <= '0;
            max_value    <= '0;
            output_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            output_ready <= 1'b0;
            busy         <= (w_next_state != ST_IDLE);
            if (r_state == ST_IDLE && inputs_ready) begin
                r_vec      <= inputs;
                r_best_val <= inputs[0];
                r_best_idx <= '0;
                r_scan_idx <= INDEX_WIDTH'(1);
            end else if (r_state == ST_SCAN) begin
                r_best_val <= w_cand_val;
                r_best_idx <= w_cand_idx;
                r_scan_idx <= r_scan_idx + INDEX_WIDTH'(1);
                if (w_last) begin
                    class_index  <= w_cand_idx;
                    max_value    <= w_cand_val;
                    output_ready <= 1'b1;
                end
            end
        end
    end

`ifdef ARGMAX_OVERRUN_FLAG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (inputs_ready && r_state != ST_IDLE) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
